// File: rtl/line_sensor_reader_if.sv
// Pixel-stream interface between the line sensor reader (producer) and the
// downstream peak-search logic (consumer).
interface line_sensor_reader_if;
  logic       start;
  logic       data_valid;
  logic [9:0] data_out;
  logic [8:0] data_pos;

  modport master (
    output start,
    output data_valid,
    output data_out,
    output data_pos
  );

  modport slave (
    input start,
    input data_valid,
    input data_out,
    input data_pos
  );
endinterface

// File: rtl/line_sensor_reader.sv
// Readout sequencer for a linear image sensor with a 10-bit ADC.
// A trigger in IDLE starts one line: a CLK_DIV-cycle shift/start pulse,
// then NUM_PIXELS pixel periods of CLK_DIV cycles each. The ADC is captured
// in the last cycle of every pixel period and presented on the pixel stream
// one cycle later. All outputs are registered; the output registers are
// loaded from the next-state values so they line up with the state register.
module line_sensor_reader #(
  parameter int unsigned NUM_PIXELS = 512,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        trigger_in,
  input  logic [9:0]                  adc_data_in,
  output logic                        sensor_sh,
  output logic                        sensor_clk,
  output logic                        busy,
  output logic                        line_done,
  output logic                        trigger_miss,
  line_sensor_reader_if.master        pix
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SH      = 2'd1;
  localparam logic [1:0] S_READOUT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // Phase counter runs 0..CLK_DIV-1 in both SH and READOUT.
  localparam logic [5:0] PH_LAST  = 6'(CLK_DIV - 1);
  localparam logic [5:0] PH_HALF  = 6'(CLK_DIV / 2);
  localparam logic [8:0] PIX_LAST = 9'(NUM_PIXELS - 1);

  logic [1:0] state_q, state_d;
  logic [5:0] phase_q, phase_d;
  logic [8:0] pix_q,   pix_d;

  logic       capture_s;

  logic       sensor_sh_q;
  logic       sensor_clk_q;
  logic       busy_q;
  logic       line_done_q;
  logic       trigger_miss_q;
  logic       start_q;
  logic       data_valid_q;
  logic [9:0] data_out_q;
  logic [8:0] data_pos_q;

  // A pixel is captured in the last phase of each READOUT period.
  assign capture_s = (state_q == S_READOUT) && (phase_q == PH_LAST);

  // Next-state logic for the sequencer, phase counter and pixel counter.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pix_d   = pix_q;
    case (state_q)
      S_IDLE: begin
        if (trigger_in) begin
          state_d = S_SH;
          phase_d = 6'd0;
          pix_d   = 9'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SH: begin
        if (phase_q == PH_LAST) begin
          state_d = S_READOUT;
          phase_d = 6'd0;
          pix_d   = 9'd0;
        end else begin
          phase_d = phase_q + 6'd1;
        end
      end
      S_READOUT: begin
        if (phase_q == PH_LAST) begin
          phase_d = 6'd0;
          // Terminal count stops the counter before it can wrap.
          if (pix_q == PIX_LAST) begin
            state_d = S_DONE;
          end else begin
            pix_d = pix_q + 9'd1;
          end
        end else begin
          phase_d = phase_q + 6'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        phase_d = 6'd0;
        pix_d   = 9'd0;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 6'd0;
        pix_d   = 9'd0;
      end
    endcase
  end

  // State, counters and registered outputs; reset returns everything to 0/IDLE.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= S_IDLE;
      phase_q        <= 6'd0;
      pix_q          <= 9'd0;
      sensor_sh_q    <= 1'b0;
      sensor_clk_q   <= 1'b0;
      busy_q         <= 1'b0;
      line_done_q    <= 1'b0;
      trigger_miss_q <= 1'b0;
      start_q        <= 1'b0;
      data_valid_q   <= 1'b0;
      data_out_q     <= 10'd0;
      data_pos_q     <= 9'd0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      pix_q          <= pix_d;
      sensor_sh_q    <= (state_d == S_SH);
      sensor_clk_q   <= (state_d == S_READOUT) && (phase_d < PH_HALF);
      busy_q         <= (state_d != S_IDLE);
      start_q        <= (state_q == S_IDLE) && trigger_in;
      data_valid_q   <= capture_s;
      line_done_q    <= capture_s && (pix_q == PIX_LAST);
      // Triggers outside IDLE are dropped but remembered until reset.
      trigger_miss_q <= trigger_miss_q | (trigger_in && (state_q != S_IDLE));
      if (capture_s) begin
        data_out_q <= adc_data_in;
        data_pos_q <= pix_q;
      end else begin
        data_out_q <= data_out_q;
        data_pos_q <= data_pos_q;
      end
    end
  end

  assign sensor_sh      = sensor_sh_q;
  assign sensor_clk     = sensor_clk_q;
  assign busy           = busy_q;
  assign line_done      = line_done_q;
  assign trigger_miss   = trigger_miss_q;
  assign pix.start      = start_q;
  assign pix.data_valid = data_valid_q;
  assign pix.data_out   = data_out_q;
  assign pix.data_pos   = data_pos_q;

endmodule

// File: tb/tb_line_sensor_reader.sv
// Directed bench for line_sensor_reader: three instances cover the
// 16-pixel/CLK_DIV=4 line, the 2-pixel/CLK_DIV=2 back-to-back case and the
// full 512-pixel boundary line.
module tb_line_sensor_reader;

  logic clk;
  int   n_total;
  int   n_bad;

  // Instance A: NUM_PIXELS=16, CLK_DIV=4
  logic       rst_a, trig_a;
  logic [9:0] adc_a;
  logic       sh_a, sclk_a, busy_a, done_a, miss_a;
  line_sensor_reader_if if_a();
  line_sensor_reader #(.NUM_PIXELS(16), .CLK_DIV(4)) u_a (
    .clk_in(clk), .rst_in(rst_a), .trigger_in(trig_a), .adc_data_in(adc_a),
    .sensor_sh(sh_a), .sensor_clk(sclk_a), .busy(busy_a), .line_done(done_a),
    .trigger_miss(miss_a), .pix(if_a)
  );

  // Instance B: NUM_PIXELS=2, CLK_DIV=2
  logic       rst_b, trig_b;
  logic [9:0] adc_b;
  logic       sh_b, sclk_b, busy_b, done_b, miss_b;
  line_sensor_reader_if if_b();
  line_sensor_reader #(.NUM_PIXELS(2), .CLK_DIV(2)) u_b (
    .clk_in(clk), .rst_in(rst_b), .trigger_in(trig_b), .adc_data_in(adc_b),
    .sensor_sh(sh_b), .sensor_clk(sclk_b), .busy(busy_b), .line_done(done_b),
    .trigger_miss(miss_b), .pix(if_b)
  );

  // Instance C: NUM_PIXELS=512, CLK_DIV=2
  logic       rst_c, trig_c;
  logic [9:0] adc_c;
  logic       sh_c, sclk_c, busy_c, done_c, miss_c;
  line_sensor_reader_if if_c();
  line_sensor_reader #(.NUM_PIXELS(512), .CLK_DIV(2)) u_c (
    .clk_in(clk), .rst_in(rst_c), .trigger_in(trig_c), .adc_data_in(adc_c),
    .sensor_sh(sh_c), .sensor_clk(sclk_c), .busy(busy_c), .line_done(done_c),
    .trigger_miss(miss_c), .pix(if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int   r;
    int   edges;
    int   cnt;
    int   done_cnt;
    logic prev_sclk;
    logic ev;

    n_total = 0;
    n_bad   = 0;
    rst_a = 1'b1; trig_a = 1'b0; adc_a = 10'd0;
    rst_b = 1'b1; trig_b = 1'b0; adc_b = 10'd0;
    rst_c = 1'b1; trig_c = 1'b0; adc_c = 10'd0;
    tick();
    tick();

    // Reset state
    chk("rst_start",  if_a.start, 1'b0);
    chk("rst_valid",  if_a.data_valid, 1'b0);
    chk("rst_data",   if_a.data_out, 10'd0);
    chk("rst_pos",    if_a.data_pos, 9'd0);
    chk("rst_sh",     sh_a, 1'b0);
    chk("rst_sclk",   sclk_a, 1'b0);
    chk("rst_busy",   busy_a, 1'b0);
    chk("rst_done",   done_a, 1'b0);
    chk("rst_miss",   miss_a, 1'b0);
    chk("rst_b_busy", busy_b, 1'b0);
    chk("rst_c_busy", busy_c, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick();

    // Test 1: single line, adc = 10 * pixel index; cycle 0 is the trigger cycle
    trig_a = 1'b1;
    tick();
    trig_a = 1'b0;
    edges = 0;
    prev_sclk = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      ev = (c >= 9) && (c <= 69) && (((c - 9) % 4) == 0);
      chk($sformatf("t1_start_c%0d", c), if_a.start, (c == 1));
      chk($sformatf("t1_sh_c%0d", c),    sh_a, (c >= 1 && c <= 4));
      chk($sformatf("t1_sclk_c%0d", c),  sclk_a, (c >= 5 && c <= 68 && ((c - 5) % 4) < 2));
      chk($sformatf("t1_valid_c%0d", c), if_a.data_valid, ev);
      chk($sformatf("t1_done_c%0d", c),  done_a, (c == 69));
      chk($sformatf("t1_busy_c%0d", c),  busy_a, (c <= 69));
      if (ev) begin
        chk($sformatf("t1_pos_c%0d", c),  if_a.data_pos, (c - 9) / 4);
        chk($sformatf("t1_data_c%0d", c), if_a.data_out, 10 * ((c - 9) / 4));
      end
      if (sclk_a && !prev_sclk) edges++;
      prev_sclk = sclk_a;
      adc_a = (c >= 5) ? 10'(10 * ((c - 1) / 4 - 1)) : 10'd0;
      tick();
    end
    chk("t1_sclk_edges", edges, 16);
    chk("t1_miss", miss_a, 1'b0);

    // Test 2: stray trigger at cycle 30 during a line
    trig_a = 1'b1;
    tick();
    trig_a = 1'b0;
    for (int c = 1; c <= 72; c++) begin
      ev = (c >= 9) && (c <= 69) && (((c - 9) % 4) == 0);
      chk($sformatf("t2_start_c%0d", c), if_a.start, (c == 1));
      chk($sformatf("t2_valid_c%0d", c), if_a.data_valid, ev);
      chk($sformatf("t2_done_c%0d", c),  done_a, (c == 69));
      chk($sformatf("t2_miss_c%0d", c),  miss_a, (c >= 31));
      if (ev) begin
        chk($sformatf("t2_pos_c%0d", c),  if_a.data_pos, (c - 9) / 4);
        chk($sformatf("t2_data_c%0d", c), if_a.data_out, 10 * ((c - 9) / 4));
      end
      trig_a = (c == 30);
      adc_a = (c >= 5) ? 10'(10 * ((c - 1) / 4 - 1)) : 10'd0;
      tick();
    end

    // Test 3: reset at cycle 40 mid-line, new trigger at cycle 45
    trig_a = 1'b1;
    tick();
    trig_a = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      if (c >= 41 && c <= 45) begin
        chk($sformatf("t3_start_c%0d", c), if_a.start, 1'b0);
        chk($sformatf("t3_valid_c%0d", c), if_a.data_valid, 1'b0);
        chk($sformatf("t3_data_c%0d", c),  if_a.data_out, 10'd0);
        chk($sformatf("t3_pos_c%0d", c),   if_a.data_pos, 9'd0);
        chk($sformatf("t3_sh_c%0d", c),    sh_a, 1'b0);
        chk($sformatf("t3_sclk_c%0d", c),  sclk_a, 1'b0);
        chk($sformatf("t3_busy_c%0d", c),  busy_a, 1'b0);
        chk($sformatf("t3_done_c%0d", c),  done_a, 1'b0);
        chk($sformatf("t3_miss_c%0d", c),  miss_a, 1'b0);
      end else begin
        r = (c <= 40) ? c : c - 45;
        ev = (r >= 9) && (r <= 69) && (((r - 9) % 4) == 0);
        chk($sformatf("t3_start_c%0d", c), if_a.start, (r == 1));
        chk($sformatf("t3_sh_c%0d", c),    sh_a, (r >= 1 && r <= 4));
        chk($sformatf("t3_valid_c%0d", c), if_a.data_valid, ev);
        chk($sformatf("t3_done_c%0d", c),  done_a, (r == 69));
        chk($sformatf("t3_busy_c%0d", c),  busy_a, (r >= 1 && r <= 69));
        chk($sformatf("t3_miss_c%0d", c),  miss_a, (c <= 40));
        if (ev) begin
          chk($sformatf("t3_pos_c%0d", c),  if_a.data_pos, (r - 9) / 4);
          chk($sformatf("t3_data_c%0d", c), if_a.data_out, 10 * ((r - 9) / 4));
        end
      end
      rst_a  = (c == 40);
      trig_a = (c == 45);
      r = (c <= 40) ? c : c - 45;
      adc_a = (r >= 5) ? 10'(10 * ((r - 1) / 4 - 1)) : 10'd0;
      tick();
    end

    // Test 4: reset and trigger in the same cycle, reset wins
    rst_a = 1'b1;
    trig_a = 1'b1;
    tick();
    rst_a = 1'b0;
    trig_a = 1'b0;
    chk("t4_busy0",  busy_a, 1'b0);
    chk("t4_start0", if_a.start, 1'b0);
    tick();
    chk("t4_busy1",  busy_a, 1'b0);
    chk("t4_sh1",    sh_a, 1'b0);

    // Test 5: trigger held high, NUM_PIXELS=2, CLK_DIV=2
    trig_b = 1'b1;
    adc_b = 10'd0;
    tick();
    for (int c = 1; c <= 16; c++) begin
      ev = (c == 5) || (c == 7) || (c == 13) || (c == 15);
      chk($sformatf("t5_start_c%0d", c), if_b.start, (c == 1) || (c == 9));
      chk($sformatf("t5_done_c%0d", c),  done_b, (c == 7) || (c == 15));
      chk($sformatf("t5_valid_c%0d", c), if_b.data_valid, ev);
      chk($sformatf("t5_busy_c%0d", c),  busy_b, (c <= 7) || (c >= 9 && c <= 15));
      chk($sformatf("t5_miss_c%0d", c),  miss_b, (c >= 2));
      if (ev) begin
        chk($sformatf("t5_pos_c%0d", c),  if_b.data_pos, (c == 7 || c == 15) ? 1 : 0);
        chk($sformatf("t5_data_c%0d", c), if_b.data_out, c - 1);
      end
      adc_b = 10'(c);
      tick();
    end
    trig_b = 1'b0;

    // Test 6: full 512-pixel line with ADC ramp equal to pixel index
    trig_c = 1'b1;
    adc_c = 10'd0;
    tick();
    trig_c = 1'b0;
    cnt = 0;
    done_cnt = 0;
    for (int c = 1; c <= 1030; c++) begin
      if (if_c.data_valid) begin
        chk($sformatf("t6_pos_%0d", cnt),  if_c.data_pos, cnt);
        chk($sformatf("t6_data_%0d", cnt), if_c.data_out, cnt);
        cnt++;
      end
      if (done_c) begin
        done_cnt++;
        chk("t6_done_cycle", c, 1027);
        chk("t6_done_valid", if_c.data_valid, 1'b1);
        chk("t6_done_pos",   if_c.data_pos, 511);
        chk("t6_done_data",  if_c.data_out, 511);
      end
      adc_c = (c >= 3) ? 10'((c - 1) / 2 - 1) : 10'd0;
      tick();
    end
    chk("t6_strobes", cnt, 512);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_busy_end", busy_c, 1'b0);
    chk("t6_miss", miss_c, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/line_sensor_reader.md
# line_sensor_reader

Readout sequencer for the linear image sensor and its 10-bit ADC. On a trigger it issues the sensor shift/start pulse, generates the pixel clock, captures one ADC sample per pixel, and emits a pixel stream on `start` / `data_valid` / `data_out` / `data_pos`. That stream feeds the peak-search logic downstream. It is the producer side of the pixel-stream interface, one instance per sensor.

## Interface
- `NUM_PIXELS`, 512: pixels per line, range 2..512; `data_pos` is 9 bits.
- `CLK_DIV`, 4: system clocks per pixel period; even, range 2..64.
- `clk_in` in 1: system clock; all logic on the rising edge.
- `rst_in` in 1: reset, synchronous, active-high.
- `trigger_in` in 1: line request; sampled only in IDLE.
- `adc_data_in` in 10: ADC output, valid by the last cycle of each pixel period.
- `sensor_sh` out 1: sensor shift/start pulse.
- `sensor_clk` out 1: sensor pixel clock.
- `start` out 1: one-cycle line-start pulse to the consumer; the consumer clears its state on it.
- `data_valid` out 1: one-cycle strobe; `data_out` and `data_pos` are valid while it is high.
- `data_out` out 10: pixel sample.
- `data_pos` out 9: pixel index, 0..NUM_PIXELS-1.
- `busy` out 1: high whenever state is not IDLE.
- `line_done` out 1: one-cycle pulse marking the last pixel of a line.
- `trigger_miss` out 1: sticky flag; cleared only by `rst_in`.

## Operation
- FSM states: IDLE, SH, READOUT, DONE.
- IDLE: `trigger_in`=1 → SH on the next cycle.
- SH: lasts exactly CLK_DIV cycles.
  - `sensor_sh`=1 for the whole state.
  - `start`=1 in its first cycle only.
  - Then → READOUT with pixel counter 0 and phase counter 0.
- READOUT: one pixel period is CLK_DIV cycles, phase counter j=0..CLK_DIV-1.
  - `sensor_clk`=1 for j<CLK_DIV/2, 0 otherwise.
  - At j=CLK_DIV-1, `adc_data_in` is registered together with the pixel counter.
  - Pixel counter increments per period.
  - After pixel NUM_PIXELS-1 is captured → DONE.
- Output of a captured pixel: the cycle after capture, `data_valid`=1 with `data_out`=sample and `data_pos`=pixel index.
- DONE: one cycle.
  - Carries `data_valid` for pixel NUM_PIXELS-1 and `line_done`=1 together.
  - Then → IDLE.
- Outside `data_valid` cycles, `data_out` and `data_pos` hold their last values; consumers use only the strobe.
- `trigger_in`=1 in any state other than IDLE:
  - The trigger is ignored, not queued.
  - `trigger_miss` is set to 1 on the next cycle.
- Pixel counter: 9 bits; its terminal count is NUM_PIXELS-1, so it never wraps within a line.
- Every line emits exactly NUM_PIXELS `data_valid` strobes, with `data_pos` strictly increasing 0..NUM_PIXELS-1.

## Timing
- Reference point: `trigger_in` is sampled high in IDLE at cycle 0.
- `sensor_sh` is high in cycles 1..CLK_DIV; `start` is high in cycle 1.
- Pixel k occupies cycles (k+1)·CLK_DIV+1 .. (k+2)·CLK_DIV.
  - Capture happens at cycle (k+2)·CLK_DIV.
  - `data_valid` is high at cycle (k+2)·CLK_DIV+1.
  - Latency from ADC sample to strobe is 1 cycle.
- `line_done` is high at cycle (NUM_PIXELS+1)·CLK_DIV+1.
- `busy` is high in cycles 1..(NUM_PIXELS+1)·CLK_DIV+1.
- A new trigger is accepted in cycle (NUM_PIXELS+1)·CLK_DIV+2 at the earliest.
- Reset values: every output is 0, including `data_out`, `data_pos` and `trigger_miss`; state is IDLE.
- Reset mid-line:
  - From the next cycle, all outputs are 0 and state is IDLE.
  - No `line_done` and no further `data_valid` for the aborted line.
- `rst_in` and `trigger_in` high in the same cycle: reset wins and the trigger is dropped.
- `trigger_in` held high continuously: it is accepted in each IDLE cycle, so back-to-back lines run with 1 idle cycle between them.
  - `trigger_miss` is set during the first line.

## Test plan
- Single line, CLK_DIV=4, NUM_PIXELS=16, `adc_data_in`=10·pixel index, trigger at cycle 0 → required response:
  - `start` at cycle 1 and `sensor_sh` high in cycles 1..4.
  - `data_valid` at cycles 9, 13, …, 69 with `data_pos` 0..15 and `data_out` 0, 10, …, 150.
  - `line_done` at cycle 69 and `busy` low at cycle 70.
- `sensor_clk` waveform, CLK_DIV=4 → pattern 1,1,0,0 per period; exactly 16 rising edges per line; `sensor_clk`=0 in IDLE and SH.
- Trigger pulse at cycle 30 during a line → line completes unchanged; `trigger_miss`=1 from cycle 31 until reset; no second `start`.
- `rst_in` at cycle 40 mid-line → all outputs 0 from cycle 41; no `line_done`; a new trigger at cycle 45 gives `start` at cycle 46.
- `trigger_in` held high, NUM_PIXELS=2, CLK_DIV=2:
  - `line_done` at cycles 7 and 15.
  - `start` at cycles 1 and 9.
- Boundary NUM_PIXELS=512, ADC ramp 0..511 → last strobe has `data_pos`=511 and `data_out`=511, coincident with `line_done`; exactly 512 strobes.
